apb_i2c_master_arb: RTL and testbench
=====================================

# apb_i2c_master_arb

APB master that shares the I2C controller's APB slave port between `N_REQ` on-chip requesters, such as a CPU bridge and a DMA engine. Each accepted request becomes one APB SETUP/ACCESS transfer, and its read data and error status return to the requester that issued it. A round-robin arbiter selects the requester. An ACCESS-phase watchdog ends any transfer the slave never completes, for example an access to an unmapped offset, which never receives PREADY.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, minimum 2.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS-phase cycles before the watchdog forces termination, minimum 1.

Ports. Clock and reset: one clock; reset is synchronous and active-low.
- `PCLK` in 1: clock. All logic is rising-edge.
- `PRESETn` in 1: reset, synchronous, active-low.

Requester side:
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_ready` out N_REQ: one-hot grant; a request is accepted on `req_valid[i] & req_ready[i]`.
- `req_write` in N_REQ: 1 = write, 0 = read.
- `req_addr` in N_REQ×32: byte address for each requester.
- `req_wdata` in N_REQ×32: write data for each requester.
- `rsp_valid` out N_REQ: one-cycle response pulse to the requester that issued the transfer; there is no backpressure.
- `rsp_rdata` out 32: PRDATA captured at completion; 0 for writes and timeouts.
- `rsp_err` out 1: PSLVERR captured at completion, or 1 on timeout.
- `rsp_timeout` out 1: 1 when the watchdog terminated the transfer.

APB master side:
- `PSELx` out 1: slave select.
- `PENABLE` out 1: ACCESS-phase strobe.
- `PWRITE` out 1: transfer direction.
- `PADDR` out 32: transfer address.
- `PWDATA` out 32: write data.
- `PRDATA` in 32: slave read data.
- `PREADY` in 1: slave completion.
- `PSLVERR` in 1: slave error.

## Operation
- State machine states:
  - IDLE: no transfer in progress.
  - SETUP: first APB cycle, `PSELx=1`, `PENABLE=0`.
  - ACCESS: `PSELx=1`, `PENABLE=1`, waiting for PREADY.
  - RESP: response cycle.
- IDLE:
  - When any `req_valid` is high, `req_ready` goes high combinationally for the winner.
  - The winner is the first requester with `req_valid` high, searching upward from `last_grant+1` modulo N_REQ.
  - On acceptance, register the winner's write, address and data into `PWRITE`, `PADDR` and `PWDATA`, latch its index as `owner`, update `last_grant`, and move to SETUP.
- SETUP: always moves to ACCESS after exactly one cycle.
- ACCESS, with the watchdog counter `wd` counting cycles spent in ACCESS from 0:
  - PREADY=1: capture `PRDATA` only if `PWRITE=0`, otherwise capture 0. Capture `PSLVERR`. Go to RESP.
  - PREADY=0 and `wd == TIMEOUT_CYCLES-1`: go to RESP with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
  - Otherwise increment `wd`.
- RESP:
  - `rsp_valid[owner]=1` for one cycle; all other `rsp_valid` bits are 0.
  - `PSELx=0`, `PENABLE=0`.
  - Next state is IDLE. No request is accepted in RESP.
- `req_ready` is 0 in every state other than IDLE.
- `PWRITE`, `PADDR` and `PWDATA` are stable from SETUP through the end of ACCESS. They hold their last value in IDLE and RESP.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` are valid only while `rsp_valid` is high.

## Timing
- Reset (`PRESETn=0` at an edge) sets:
  - state to IDLE;
  - `PSELx`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA` to 0;
  - `rsp_valid` and the response fields to 0;
  - `wd` to 0;
  - `last_grant` to N_REQ-1, so requester 0 has first priority.
- Reset mid-transfer:
  - The bus is released at the next edge.
  - No response is issued; the in-flight request is lost.
- Cycle sequence, with acceptance at cycle t:
  - t+1: SETUP.
  - t+2: first ACCESS cycle.
  - k ≥ 0 wait states follow.
  - `rsp_valid` at t+3+k.
  - IDLE at t+4+k.
- Minimum of 4 cycles per transfer.
- Timeout case: ACCESS occupies t+2 through t+1+TIMEOUT_CYCLES, and `rsp_valid` is asserted at t+2+TIMEOUT_CYCLES.
- Requests on the same cycle are arbitrated round-robin. A requester that keeps `req_valid` high is served within N_REQ transfers.
- Deasserting `req_valid` before acceptance is permitted. Request fields are sampled only in the accept cycle.

## Structure
- Shared package `apb_i2c_pkg` holds:
  - the state enum;
  - the I2C register offsets: `ADDR_TX=0`, `ADDR_RX=4`, `ADDR_CONFIG=8`, `ADDR_TIMEOUT=12`;
  - the data width constant (32).
- Sub-module `rr_arbiter` (parameter `N`): inputs `req[N]`, an `advance` strobe and the registered `last_grant`; output one-hot `grant[N]`. It is combinational, plus the `last_grant` register, which updates on `advance`.
- Top level: FSM, APB output registers, watchdog counter of width `$clog2(TIMEOUT_CYCLES+1)`, response registers.

## Test plan
- **Config write:** requester 0 writes `0x8 ← 0x00003A5C`; slave gives PREADY on the first ACCESS cycle.
  - Required: SETUP then one ACCESS with `PADDR=8`, `PWDATA=0x3A5C`.
  - Required: `rsp_valid[0]` 3 cycles after acceptance, `rsp_err=0`, `rsp_rdata=0`.
- **RX read with wait states:** requester 1 reads `0x4`; slave inserts 2 wait states and returns `PRDATA=0xA5`.
  - Required: `rsp_valid[1]` at t+5 with `rsp_rdata=0xA5`.
  - Required: `PADDR` stable throughout the transfer.
- **Simultaneous requests:** both requesters assert continuously from reset.
  - Required: grants in order 0, 1, 0, 1.
  - Required: each response goes to the correct index; no `rsp_valid` bit asserts for the wrong owner.
- **Unmapped address:** read of `0x10`; PREADY is never asserted; `TIMEOUT_CYCLES=16`.
  - Required: exactly 16 ACCESS cycles, then bus released.
  - Required: `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
- **Slave error:** PSLVERR=1 together with PREADY on a write to `0x0`.
  - Required: `rsp_err=1`, `rsp_timeout=0`.
- **Reset mid-transfer:** `PRESETn` low for one edge during ACCESS.
  - Required: `PSELx` and `PENABLE` are 0 the next cycle; no `rsp_valid`.
  - Required: requester 0 is granted first afterward.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// rtl/apb_i2c_pkg.sv - shared types and constants for the APB I2C master arbiter
package apb_i2c_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ADDR_TX      = 32'h0000_0000;
    localparam logic [DATA_W-1:0] ADDR_RX      = 32'h0000_0004;
    localparam logic [DATA_W-1:0] ADDR_CONFIG  = 32'h0000_0008;
    localparam logic [DATA_W-1:0] ADDR_TIMEOUT = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection with registered last_grant
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Search upward from last_grant+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand_idx  = '0;
        for (int off = 1; off <= N; off++) begin
            cand_idx = IDX_W'((int'(last_grant) + off) % N);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            last_grant <= IDX_W'(N - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_i2c_master_arb.sv
// rtl/apb_i2c_master_arb.sv - N-requester APB master with round-robin arbitration and ACCESS watchdog
module apb_i2c_master_arb
    import apb_i2c_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_write,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic                         PSELx,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W-1:0]            PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    apb_state_e       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] grant;
    logic [WD_W-1:0]  wd;
    logic             accept;

    assign accept    = (state == ST_IDLE) && (|req_valid);
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            owner       <= '0;
            wd          <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        PWRITE <= req_write[win_idx];
                        PADDR  <= req_addr[win_idx];
                        PWDATA <= req_wdata[win_idx];
                        owner  <= win_idx;
                        PSELx  <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    wd      <= '0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= ONE << owner;
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        wd          <= '0;
                        state       <= ST_RESP;
                    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Slave never answered: release the bus and report a timeout.
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= ONE << owner;
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        wd          <= '0;
                        state       <= ST_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_master_arb.sv
// tb/tb_apb_i2c_master_arb.sv - directed self-checking bench for apb_i2c_master_arb
module tb_apb_i2c_master_arb;
    import apb_i2c_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic                    PCLK = 1'b0;
    logic                    PRESETn = 1'b0;
    logic [N-1:0]            req_valid = '0;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            req_write = '0;
    logic [N-1:0][31:0]      req_addr = '0;
    logic [N-1:0][31:0]      req_wdata = '0;
    logic [N-1:0]            rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;
    logic                    PSELx, PENABLE, PWRITE;
    logic [31:0]             PADDR, PWDATA, PRDATA;
    logic                    PREADY, PSLVERR;

    apb_i2c_master_arb #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave model: answers after wait_cfg wait states unless hung.
    int          acc_cnt = 0;
    int          wait_cfg = 0;
    logic        hang = 1'b0;
    logic        err_cfg = 1'b0;
    logic [31:0] slave_rdata = 32'h0;

    always @(posedge PCLK) begin
        if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                             acc_cnt <= 0;
    end
    assign PREADY  = PSELx && PENABLE && !hang && (acc_cnt == wait_cfg);
    assign PRDATA  = slave_rdata;
    assign PSLVERR = PREADY && err_cfg;

    int          acc_total = 0, setup_total = 0, paddr_changes = 0;
    int          rsp_count = 0, grant_n = 0, accept_cyc = 0, rsp_cyc = 0;
    logic [31:0] setup_addr = '0, acc_addr = '0, acc_wdata = '0, rsp_rd = '0;
    logic [N-1:0] rsp_vec = '0;
    logic        rsp_e = 1'b0, rsp_t = 1'b0;
    logic [N-1:0] grant_log [32];
    logic [N-1:0] rsp_log [32];

    always @(negedge PCLK) begin
        if (PSELx && !PENABLE) begin
            setup_total++;
            setup_addr = PADDR;
        end
        if (PSELx && PENABLE) begin
            acc_total++;
            acc_addr  = PADDR;
            acc_wdata = PWDATA;
            if (PADDR !== setup_addr) paddr_changes++;
        end
        if (PRESETn && ((req_ready & req_valid) != '0)) begin
            accept_cyc = cyc;
            if (grant_n < 32) grant_log[grant_n] = req_ready;
            grant_n++;
        end
        if (rsp_valid != '0) begin
            rsp_cyc = cyc;
            rsp_vec = rsp_valid;
            rsp_rd  = rsp_rdata;
            rsp_e   = rsp_err;
            rsp_t   = rsp_timeout;
            if (rsp_count < 32) rsp_log[rsp_count] = rsp_valid;
            rsp_count++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset;
        PRESETn = 1'b0;
        tick;
        tick;
        PRESETn = 1'b1;
    endtask

    task automatic issue(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int i;
        req_write[idx] = wr;
        req_addr[idx]  = addr;
        req_wdata[idx] = data;
        req_valid[idx] = 1'b1;
        i = 0;
        #1;
        while (!req_ready[idx] && i < 20) begin
            tick;
            #1;
            i++;
        end
        check("accept_bound", 32'(req_ready[idx]), 32'd1);
        tick;
        req_valid[idx] = 1'b0;
        // Scramble fields after acceptance; the DUT must have latched them already.
        req_addr[idx]  = 32'hFFFF_FFFF;
        req_wdata[idx] = 32'hFFFF_FFFF;
        req_write[idx] = ~wr;
    endtask

    task automatic wait_rsp(input int n_before, input int budget);
        int i;
        i = 0;
        while (rsp_count == n_before && i < budget) begin
            tick;
            i++;
        end
        check("rsp_bound", 32'(rsp_count > n_before), 32'd1);
    endtask

    int r0, a0, s0, p0, g0;
    logic [N-1:0] exp_order [4];

    initial begin
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        repeat (3) tick;
        check("rst_psel",      32'(PSELx),     32'd0);
        check("rst_penable",   32'(PENABLE),   32'd0);
        check("rst_pwrite",    32'(PWRITE),    32'd0);
        check("rst_paddr",     PADDR,          32'd0);
        check("rst_pwdata",    PWDATA,         32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        PRESETn = 1'b1;
        tick;

        // Config write, zero wait states
        slave_rdata = 32'h1234_5678;
        r0 = rsp_count; a0 = acc_total; s0 = setup_total;
        issue(0, 1'b1, ADDR_CONFIG, 32'h0000_3A5C);
        wait_rsp(r0, 40);
        check("cfg_latency",  32'(rsp_cyc - accept_cyc), 32'd3);
        check("cfg_setups",   32'(setup_total - s0),     32'd1);
        check("cfg_accesses", 32'(acc_total - a0),       32'd1);
        check("cfg_paddr",    acc_addr,                  32'h8);
        check("cfg_pwdata",   acc_wdata,                 32'h3A5C);
        check("cfg_rsp_vec",  32'(rsp_vec),              32'b01);
        check("cfg_err",      32'(rsp_e),                32'd0);
        check("cfg_rdata",    rsp_rd,                    32'd0);

        // RX read with two wait states
        wait_cfg = 2; slave_rdata = 32'h0000_00A5;
        r0 = rsp_count; a0 = acc_total; p0 = paddr_changes;
        issue(1, 1'b0, ADDR_RX, 32'h0);
        wait_rsp(r0, 40);
        check("rx_latency",  32'(rsp_cyc - accept_cyc), 32'd5);
        check("rx_accesses", 32'(acc_total - a0),       32'd3);
        check("rx_paddr",    acc_addr,                  32'h4);
        check("rx_stable",   32'(paddr_changes - p0),   32'd0);
        check("rx_rsp_vec",  32'(rsp_vec),              32'b10);
        check("rx_rdata",    rsp_rd,                    32'hA5);
        check("rx_err",      32'(rsp_e),                32'd0);
        wait_cfg = 0;

        // Simultaneous requests held from reset
        req_write = '0;
        req_addr[0] = ADDR_TX; req_addr[1] = ADDR_RX;
        req_valid = 2'b11;
        r0 = rsp_count; g0 = grant_n;
        do_reset;
        begin
            int i;
            i = 0;
            while (rsp_count < r0 + 4 && i < 60) begin
                tick;
                i++;
            end
        end
        req_valid = '0;
        check("rr_rsp_count", 32'(rsp_count - r0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k), 32'(grant_log[g0 + k]), 32'(exp_order[k]));
            check($sformatf("rr_rsp%0d", k),   32'(rsp_log[r0 + k]),   32'(exp_order[k]));
        end

        // Unmapped offset: slave never answers
        hang = 1'b1; slave_rdata = 32'hDEAD_BEEF;
        r0 = rsp_count; a0 = acc_total;
        issue(0, 1'b0, 32'h10, 32'h0);
        wait_rsp(r0, 60);
        check("to_latency",  32'(rsp_cyc - accept_cyc), 32'(TO + 2));
        check("to_accesses", 32'(acc_total - a0),       32'(TO));
        check("to_rsp_vec",  32'(rsp_vec),              32'b01);
        check("to_err",      32'(rsp_e),                32'd1);
        check("to_flag",     32'(rsp_t),                32'd1);
        check("to_rdata",    rsp_rd,                    32'd0);
        check("to_psel_rel", 32'(PSELx),                32'd0);
        check("to_pen_rel",  32'(PENABLE),              32'd0);
        hang = 1'b0;

        // Slave error on a write
        err_cfg = 1'b1;
        r0 = rsp_count;
        issue(1, 1'b1, ADDR_TX, 32'h55);
        wait_rsp(r0, 40);
        check("se_rsp_vec", 32'(rsp_vec), 32'b10);
        check("se_err",     32'(rsp_e),   32'd1);
        check("se_timeout", 32'(rsp_t),   32'd0);
        check("se_rdata",   rsp_rd,       32'd0);
        err_cfg = 1'b0;

        // Reset during ACCESS
        hang = 1'b1;
        issue(1, 1'b0, ADDR_TIMEOUT, 32'h0);
        tick;
        tick;
        check("mr_in_access", 32'(PSELx && PENABLE), 32'd1);
        PRESETn = 1'b0;
        tick;
        PRESETn = 1'b1;
        check("mr_psel",    32'(PSELx),   32'd0);
        check("mr_penable", 32'(PENABLE), 32'd0);
        r0 = rsp_count;
        repeat (30) tick;
        check("mr_no_rsp", 32'(rsp_count - r0), 32'd0);
        hang = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mr_first_grant", 32'(req_ready), 32'b01);
        tick;
        req_valid = '0;
        wait_rsp(r0, 40);
        check("mr_rsp_vec", 32'(rsp_vec), 32'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
